// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam logic [3:0] OVERSAMPLE_MID  = 4'd7;
  localparam logic [3:0] OVERSAMPLE_LAST = 4'd15;
  localparam int         UART_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte recovery from a 16x-oversampled serial line, with input synchronizer.
// state | meaning
// IDLE  | line idle, waiting for a low sample
// START | confirming start bit at mid-bit
// DATA  | sampling data bits LSB-first
// STOP  | sampling stop bit
// BREAK | bad stop seen, waiting for line to return high
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int UART_WIDTH = UART_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_tick,
  input  logic                  rx,
  output logic [UART_WIDTH-1:0] byte_data,
  output logic                  byte_ok,
  output logic                  byte_err,
  output logic                  start_det,
  output logic                  idle
);

  localparam int BIT_W = (UART_WIDTH > 1) ? $clog2(UART_WIDTH) : 1;

  rx_state_t             state_q, state_d;
  logic                  rx_m, rx_s;
  logic [3:0]            cnt_q;
  logic [BIT_W-1:0]      bit_q;
  logic [UART_WIDTH-1:0] shift_q;
  logic                  mid, last, last_bit;

  assign mid      = (cnt_q == OVERSAMPLE_MID);
  assign last     = (cnt_q == OVERSAMPLE_LAST);
  assign last_bit = (bit_q == BIT_W'(UART_WIDTH - 1));

  // Preset high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          state_q <= IDLE;
    else if (uart_tick) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (mid) state_d = rx_s ? IDLE : DATA;
      DATA:    if (last && last_bit) state_d = STOP;
      STOP:    if (last) state_d = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The 4-bit sample counter wraps 15 -> 0 on its own at each bit boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else if (uart_tick) begin
      case (state_q)
        START: begin
          cnt_q <= mid ? 4'd0 : cnt_q + 4'd1;
          bit_q <= '0;
        end
        DATA: begin
          cnt_q <= cnt_q + 4'd1;
          if (last) begin
            shift_q <= {rx_s, shift_q[UART_WIDTH-1:1]};
            bit_q   <= last_bit ? '0 : bit_q + BIT_W'(1);
          end
        end
        STOP:    cnt_q <= cnt_q + 4'd1;
        default: cnt_q <= '0;
      endcase
    end
  end

  always_comb begin
    byte_ok   = 1'b0;
    byte_err  = 1'b0;
    start_det = 1'b0;
    idle      = (state_q == IDLE);
    if (uart_tick && state_q == STOP && last) begin
      byte_ok  = rx_s;
      byte_err = !rx_s;
    end
    if (uart_tick && state_q == IDLE && !rx_s) start_det = 1'b1;
  end

  assign byte_data = shift_q;

endmodule

// File: rtl/uart_rx_word.sv
// Reassembles consecutive UART bytes (LSB byte first) into one word, with
// an idle timeout that discards a partially received word.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int BYTE           = 2,
  parameter int DATA_OUT_WIDTH = 12,
  parameter int UART_WIDTH     = UART_WIDTH_DEFAULT,
  parameter int OVERSAMPLE     = 16,
  parameter int TIMEOUT_BITS   = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      uart_tick,
  input  logic                      Rx,
  output logic [DATA_OUT_WIDTH-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      rx_frame_err,
  output logic                      rx_timeout,
  output logic                      rx_busy
);

  localparam int WORD_W   = UART_WIDTH * BYTE;
  localparam int IDX_W    = (BYTE > 1) ? $clog2(BYTE) : 1;
  localparam int TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  logic [UART_WIDTH-1:0] byte_data;
  logic                  byte_ok, byte_err, start_det, idle;
  logic [IDX_W-1:0]      byte_idx;
  logic [WORD_W-1:0]     asm_q, word_full;
  logic [TO_W-1:0]       to_q;
  logic                  idx_last;

  uart_rx_byte #(.UART_WIDTH(UART_WIDTH)) u_byte (
    .clk       (clk),
    .reset     (reset),
    .uart_tick (uart_tick),
    .rx        (Rx),
    .byte_data (byte_data),
    .byte_ok   (byte_ok),
    .byte_err  (byte_err),
    .start_det (start_det),
    .idle      (idle)
  );

  assign idx_last = (byte_idx == IDX_W'(BYTE - 1));

  // Incoming byte merged into its slot; bits above the word width are dropped.
  always_comb begin
    word_full = asm_q;
    word_full[byte_idx*UART_WIDTH +: UART_WIDTH] = byte_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_timeout   <= 1'b0;
      byte_idx     <= '0;
      asm_q        <= '0;
      to_q         <= '0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_timeout   <= 1'b0;

      if (start_det) begin
        to_q <= '0;
      end else if (uart_tick && idle && byte_idx != '0) begin
        if (to_q == TO_W'(TO_LIMIT - 1)) begin
          to_q       <= '0;
          rx_timeout <= 1'b1;
          byte_idx   <= '0;
        end else begin
          to_q <= to_q + TO_W'(1);
        end
      end

      if (byte_ok) begin
        if (idx_last) begin
          rx_data  <= word_full[DATA_OUT_WIDTH-1:0];
          rx_valid <= 1'b1;
          byte_idx <= '0;
        end else begin
          asm_q    <= word_full;
          byte_idx <= byte_idx + IDX_W'(1);
        end
      end else if (byte_err) begin
        rx_frame_err <= 1'b1;
        byte_idx     <= '0;
      end
    end
  end

  assign rx_busy = !idle || (byte_idx != '0);

endmodule

// File: tb/tb_uart_rx_word.sv
// Self-checking bench for uart_rx_word: vector table plus hand-written corner sequences.
module tb_uart_rx_word;

  localparam int TICK_DIV = 2;
  localparam int BIT_T    = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_tick = 1'b0;
  logic        Rx = 1'b1;
  logic [11:0] rx_data;
  logic        rx_valid, rx_frame_err, rx_timeout, rx_busy;

  int checks = 0;
  int failures = 0;
  int n_valid = 0, n_err = 0, n_to = 0;
  int div = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic        hi_stop;
    logic [11:0] exp_data;
    int          exp_valid;
    int          exp_err;
  } vec_t;

  vec_t vecs [6];

  uart_rx_word dut (
    .clk          (clk),
    .reset        (reset),
    .uart_tick    (uart_tick),
    .Rx           (Rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_timeout   (rx_timeout),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div = (div == TICK_DIV - 1) ? 0 : div + 1;
    uart_tick = (div == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every rx_valid pops the oldest expected word.
  always @(posedge clk) begin
    #1;
    if (rx_valid) begin
      n_valid++;
      if (exp_q.size() == 0) check("unexpected_valid", 32'(rx_data), 32'hFFFF_FFFF);
      else check("valid_data", 32'(rx_data), 32'(exp_q.pop_front()));
    end
    if (rx_frame_err) n_err++;
    if (rx_timeout) n_to++;
    if (rx_valid || rx_frame_err || rx_timeout)
      check("pulse_exclusive", 32'(rx_valid) + 32'(rx_frame_err) + 32'(rx_timeout), 32'd1);
  end

  task automatic wait_ticks(input int n);
    repeat (n * TICK_DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    Rx = 1'b0;
    wait_ticks(BIT_T);
    for (int i = 0; i < 8; i++) begin
      Rx = d[i];
      wait_ticks(BIT_T);
    end
    Rx = stop;
    wait_ticks(BIT_T);
  endtask

  task automatic send_word(input logic [11:0] w, input int gap);
    exp_q.push_back(w);
    send_frame(w[7:0], 1'b1);
    Rx = 1'b1;
    wait_ticks(gap * BIT_T);
    send_frame({4'h0, w[11:8]}, 1'b1);
    Rx = 1'b1;
    wait_ticks(gap * BIT_T);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    wait_ticks(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0, t0;
    vecs[0] = '{8'hBC, 8'h0A, 1'b1, 12'hABC, 1, 0};
    vecs[1] = '{8'h00, 8'h00, 1'b1, 12'h000, 1, 0};
    vecs[2] = '{8'hFF, 8'h0F, 1'b1, 12'hFFF, 1, 0};
    vecs[3] = '{8'h34, 8'hF2, 1'b1, 12'h234, 1, 0};
    vecs[4] = '{8'h11, 8'h22, 1'b0, 12'h234, 0, 1};
    vecs[5] = '{8'hA5, 8'h05, 1'b1, 12'h5A5, 1, 0};

    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_data", 32'(rx_data), 32'h0);
    check("reset_valid", 32'(rx_valid), 32'h0);
    check("reset_err", 32'(rx_frame_err), 32'h0);
    check("reset_timeout", 32'(rx_timeout), 32'h0);
    check("reset_busy", 32'(rx_busy), 32'h0);
    wait_ticks(2 * BIT_T);

    for (int i = 0; i < 6; i++) begin
      v0 = n_valid; e0 = n_err; t0 = n_to;
      if (vecs[i].exp_valid != 0) exp_q.push_back(vecs[i].exp_data);
      send_frame(vecs[i].lo, 1'b1);
      Rx = 1'b1;
      wait_ticks(2 * BIT_T);
      send_frame(vecs[i].hi, vecs[i].hi_stop);
      Rx = 1'b1;
      wait_ticks(2 * BIT_T);
      wait_drain();
      check("vec_data", 32'(rx_data), 32'(vecs[i].exp_data));
      check("vec_valid_cnt", 32'(n_valid - v0), 32'(vecs[i].exp_valid));
      check("vec_err_cnt", 32'(n_err - e0), 32'(vecs[i].exp_err));
      check("vec_timeout_cnt", 32'(n_to - t0), 32'd0);
      check("vec_busy", 32'(rx_busy), 32'd0);
    end

    // Bad stop, then line held low: one error, no repeated 0x00 frames.
    v0 = n_valid; e0 = n_err;
    send_frame(8'hFF, 1'b0);
    check("ferr_pulse", 32'(n_err - e0), 32'd1);
    wait_ticks(40 * BIT_T);
    check("break_err_cnt", 32'(n_err - e0), 32'd1);
    check("break_valid_cnt", 32'(n_valid - v0), 32'd0);
    check("break_busy", 32'(rx_busy), 32'd1);
    Rx = 1'b1;
    wait_ticks(2 * BIT_T);
    check("break_exit_busy", 32'(rx_busy), 32'd0);
    send_word(12'h123, 2);
    wait_drain();
    check("after_break_data", 32'(rx_data), 32'h123);

    // Short glitch is rejected as a false start.
    v0 = n_valid; e0 = n_err; t0 = n_to;
    Rx = 1'b0;
    wait_ticks(5);
    Rx = 1'b1;
    wait_ticks(BIT_T);
    check("glitch_busy", 32'(rx_busy), 32'd0);
    check("glitch_pulses", 32'((n_valid - v0) + (n_err - e0) + (n_to - t0)), 32'd0);

    // Single byte then idle: timeout fires after 20 bit-times, not before.
    t0 = n_to; v0 = n_valid;
    send_frame(8'h55, 1'b1);
    check("partial_busy", 32'(rx_busy), 32'd1);
    wait_ticks(19 * BIT_T);
    check("timeout_not_early", 32'(n_to - t0), 32'd0);
    wait_ticks(2 * BIT_T);
    check("timeout_pulse", 32'(n_to - t0), 32'd1);
    check("timeout_busy", 32'(rx_busy), 32'd0);
    check("timeout_no_valid", 32'(n_valid - v0), 32'd0);
    send_word(12'h0F0, 2);
    wait_drain();
    check("after_timeout_data", 32'(rx_data), 32'h0F0);

    // Reset in the middle of the second byte of 12'h777.
    v0 = n_valid;
    send_frame(8'h77, 1'b1);
    Rx = 1'b1;
    wait_ticks(2 * BIT_T);
    Rx = 1'b0;
    wait_ticks(BIT_T);
    for (int i = 0; i < 3; i++) begin
      Rx = 1'b1;
      wait_ticks(BIT_T);
    end
    reset = 1'b1;
    Rx = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_data", 32'(rx_data), 32'h0);
    check("midreset_busy", 32'(rx_busy), 32'h0);
    check("midreset_valid", 32'(rx_valid), 32'h0);
    reset = 1'b0;
    wait_ticks(2 * BIT_T);
    check("midreset_no_valid", 32'(n_valid - v0), 32'd0);
    send_word(12'h5A5, 2);
    wait_drain();
    check("after_reset_data", 32'(rx_data), 32'h5A5);

    // Back-to-back words with no idle time between frames.
    v0 = n_valid; e0 = n_err;
    send_word(12'h001, 0);
    send_word(12'hFFF, 0);
    send_word(12'h800, 0);
    Rx = 1'b1;
    wait_ticks(2 * BIT_T);
    wait_drain();
    check("b2b_valid_cnt", 32'(n_valid - v0), 32'd3);
    check("b2b_err_cnt", 32'(n_err - e0), 32'd0);
    check("b2b_last_data", 32'(rx_data), 32'h800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
